// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_checker
// Brief    : Self-synchronising PRBS31 (x^31 + x^28 + 1) serial checker with
//            flywheel lock, saturating error counter and windowed loss-of-lock.
// Revision : 1.0 - initial release
// ============================================================================
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int WIN_LEN     = 256,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             lock_lost
);

  localparam int c_match_w = $clog2(LOCK_COUNT + 1);
  localparam int c_win_w   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int c_werr_w  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state,     w_state;
  logic [30:0]           r_sr,        w_sr;
  logic [4:0]            r_fill,      w_fill;
  logic [c_match_w-1:0]  r_match,     w_match;
  logic [c_win_w-1:0]    r_win,       w_win;
  logic [c_werr_w-1:0]   r_werr,      w_werr;
  logic                  r_err_pulse;
  logic [ERR_W-1:0]      r_err_count, w_err_count;
  logic                  r_lock_lost, w_lock_lost;

  logic                  w_exp;
  logic                  w_wrap;
  logic                  w_err;
  logic                  w_loss;
  logic [c_werr_w-1:0]   w_werr_inc;

  assign w_exp  = r_sr[27] ^ r_sr[30];
  assign w_wrap = (r_win == c_win_w'(WIN_LEN - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sr        <= w_sr;
      r_fill      <= w_fill;
      r_match     <= w_match;
      r_win       <= w_win;
      r_werr      <= w_werr;
      r_err_pulse <= w_err;
      r_err_count <= w_err_count;
      r_lock_lost <= w_lock_lost;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_sr       = r_sr;
    w_fill     = r_fill;
    w_match    = r_match;
    w_win      = r_win;
    w_werr     = r_werr;
    w_werr_inc = '0;
    w_err      = 1'b0;
    w_loss     = 1'b0;

    if (bit_valid) begin
      case (r_state)
        ST_HUNT: begin
          w_sr = {r_sr[29:0], bit_in};
          if (r_fill != 5'd31) begin
            w_fill = r_fill + 5'd1;
          end else if ((bit_in == w_exp) && (r_sr != '0)) begin
            if (r_match == c_match_w'(LOCK_COUNT - 1)) begin
              w_state = ST_LOCKED;
              w_match = '0;
              w_win   = '0;
              w_werr  = '0;
            end else begin
              w_match = r_match + c_match_w'(1);
            end
          end else begin
            w_match = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: the local sequence advances on its own prediction.
          w_sr       = {r_sr[29:0], w_exp};
          w_err      = (bit_in != w_exp);
          w_win      = w_wrap ? '0 : r_win + c_win_w'(1);
          w_werr_inc = (w_wrap ? '0 : r_werr) + c_werr_w'(w_err);
          if (w_werr_inc == c_werr_w'(LOSS_THRESH)) begin
            w_state = ST_HUNT;
            w_fill  = '0;
            w_match = '0;
            w_win   = '0;
            w_werr  = '0;
            w_loss  = 1'b1;
          end else begin
            w_werr  = w_werr_inc;
          end
        end

        default: w_state = ST_HUNT;
      endcase
    end

    // Clear takes effect first so a coincident error or loss still registers.
    w_err_count = clr_cnt ? '0 : r_err_count;
    if (w_err && (w_err_count != '1)) begin
      w_err_count = w_err_count + ERR_W'(1);
    end
    w_lock_lost = (clr_cnt ? 1'b0 : r_lock_lost) | w_loss;
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs31_checker
// Brief    : Self-checking bench for prbs31_checker against a sequence-level
//            reference model (recurrence on bit history, window indexing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs31_checker;

  localparam int LOCK_COUNT  = 64;
  localparam int WIN_LEN     = 256;
  localparam int LOSS_THRESH = 8;
  localparam int ERR_W       = 4;
  localparam int CNT_MAX     = (1 << ERR_W) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             bit_in    = 1'b0;
  logic             bit_valid = 1'b0;
  logic             clr_cnt   = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             lock_lost;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs31_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .WIN_LEN    (WIN_LEN),
    .LOSS_THRESH(LOSS_THRESH),
    .ERR_W      (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .lock_lost(lock_lost)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  // Stimulus source: PRBS31 generator seeded with 1.
  logic [30:0] g = 31'd1;
  function automatic logic gen_bit();
    logic b;
    b = g[27] ^ g[30];
    g = {g[29:0], b};
    return b;
  endfunction

  // Reference model: history queue (oldest first), b[n] = b[n-28] ^ b[n-31].
  bit m_q[$];
  int m_locked, m_fill, m_run, m_k, m_wid, m_werr, m_cnt, m_lost, m_pulse;

  task automatic model_step();
    int  err, loss, pred, nz, w;
    if (rst_n) begin
      m_q.delete();
      for (int i = 0; i < 31; i++) m_q.push_back(1'b0);
      m_locked = 0; m_fill = 0; m_run = 0; m_k = 0; m_wid = 0; m_werr = 0;
      m_cnt = 0; m_lost = 0; m_pulse = 0;
      return;
    end
    err  = 0;
    loss = 0;
    if (bit_valid) begin
      pred = m_q[3] ^ m_q[0];
      if (m_locked == 0) begin
        nz = 0;
        foreach (m_q[i]) if (m_q[i]) nz = 1;
        if (m_fill < 31) m_fill++;
        else if ((int'(bit_in) == pred) && (nz != 0)) m_run++;
        else m_run = 0;
        m_q.push_back(bit_in);
        void'(m_q.pop_front());
        if (m_run == LOCK_COUNT) begin
          m_locked = 1; m_run = 0; m_k = 0; m_wid = 0; m_werr = 0;
        end
      end else begin
        err = (int'(bit_in) != pred);
        m_q.push_back(pred[0]);
        void'(m_q.pop_front());
        w = (m_k + 1) / WIN_LEN;
        if (w != m_wid) begin
          m_wid  = w;
          m_werr = 0;
        end
        m_werr += err;
        m_k++;
        if (m_werr == LOSS_THRESH) begin
          m_locked = 0; loss = 1; m_fill = 0; m_run = 0;
        end
      end
    end
    if (clr_cnt) begin
      m_cnt  = 0;
      m_lost = 0;
    end
    if (err != 0 && m_cnt < CNT_MAX) m_cnt++;
    if (loss != 0) m_lost = 1;
    m_pulse = err;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cyc_locked",    int'(locked),    m_locked);
      check("cyc_err_pulse", int'(err_pulse), m_pulse);
      check("cyc_err_count", int'(err_count), m_cnt);
      check("cyc_lock_lost", int'(lock_lost), m_lost);
    end
  end

  // Drive at a falling edge; returns after the rising edge has consumed it.
  task automatic step(input logic v, input logic b, input logic c);
    bit_valid = v;
    bit_in    = b;
    clr_cnt   = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    g     = 31'd1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
  endtask

  task automatic send(input int n, input logic inv);
    for (int i = 0; i < n; i++) step(1'b1, gen_bit() ^ inv, 1'b0);
  endtask

  initial begin
    logic b, v, f, c;
    @(negedge clk);
    do_reset();
    check("rst_locked",    int'(locked),    0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_lock_lost", int'(lock_lost), 0);

    // Ideal stream: lock exactly after valid bit 95, then 10000 clean bits.
    send(94, 1'b0);
    check("ideal_unlocked_94", int'(locked), 0);
    send(1, 1'b0);
    check("ideal_locked_95", int'(locked), 1);
    send(10000 - 95, 1'b0);
    check("ideal_err_count", int'(err_count), 0);

    // Single flipped bit.
    step(1'b1, ~gen_bit(), 1'b0);
    check("flip_pulse", int'(err_pulse), 1);
    check("flip_count", int'(err_count), 1);
    check("flip_locked", int'(locked), 1);
    send(1, 1'b0);
    check("flip_pulse_after", int'(err_pulse), 0);

    // Clear coincident with an error.
    step(1'b1, ~gen_bit(), 1'b1);
    check("clr_err_count", int'(err_count), 1);
    send(50, 1'b0);

    // Inverted stream after a fresh lock: 8 errors then loss, never relocks.
    do_reset();
    send(100, 1'b0);
    check("inv_pre_locked", int'(locked), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ~gen_bit(), 1'b0);
      check("inv_pulse", int'(err_pulse), 1);
      check("inv_locked", int'(locked), (i < 7) ? 1 : 0);
    end
    check("inv_err_count", int'(err_count), 8);
    check("inv_lock_lost", int'(lock_lost), 1);
    send(1000, 1'b1);
    check("inv_no_relock", int'(locked), 0);
    step(1'b0, 1'b0, 1'b1);
    check("inv_clr_lost", int'(lock_lost), 0);
    check("inv_clr_count", int'(err_count), 0);

    // Stuck-at inputs never lock.
    do_reset();
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0);
    check("stuck0_locked", int'(locked), 0);
    do_reset();
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 1'b0);
    check("stuck1_locked", int'(locked), 0);

    // Gapped valid: lock after 95 valid bits (190 cycles).
    do_reset();
    for (int i = 1; i <= 95; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      if (i == 95) check("gap_locked_95", int'(locked), 1);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 94) check("gap_unlocked_94", int'(locked), 0);
    end
    for (int i = 0; i < 200; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check("gap_err_count", int'(err_count), 0);

    // Saturation: 7 errors per window keeps lock while err_count pins at max.
    do_reset();
    send(95, 1'b0);
    for (int k = 0; k < 800; k++) step(1'b1, gen_bit() ^ ((k % 37) == 0), 1'b0);
    check("sat_err_count", int'(err_count), CNT_MAX);
    check("sat_locked", int'(locked), 1);

    // Reset mid-lock clears outputs without waiting for a clock edge.
    rst_n = 1'b1;
    #1;
    check("midrst_locked", int'(locked), 0);
    check("midrst_err_count", int'(err_count), 0);
    check("midrst_err_pulse", int'(err_pulse), 0);
    check("midrst_lock_lost", int'(lock_lost), 0);
    @(negedge clk);
    rst_n = 1'b0;
    g     = 31'd1;
    send(94, 1'b0);
    check("relock_94", int'(locked), 0);
    send(1, 1'b0);
    check("relock_95", int'(locked), 1);

    // Randomised traffic: sparse then denser errors, random gaps and clears.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 3000; i++) begin
        v = ($urandom_range(0, 3) != 0);
        b = v ? gen_bit() : 1'($urandom_range(0, 1));
        f = (phase == 0) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 39) == 0);
        c = ($urandom_range(0, 63) == 0);
        step(v, b ^ f, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Serial PRBS31 receiver/checker (polynomial x^31 + x^28 + 1). It sits directly downstream of the PRBS31 generator stage and consumes its 1-bit stream, either looped back on-chip or returned via an external pin.
- It self-synchronises to the incoming stream, declares lock, and then free-runs a local copy of the sequence (flywheel mode).
- It counts bit errors against that local copy and drops lock when the error density is too high.

Parameters:
- LOCK_COUNT, 64: consecutive matching bits required in HUNT before declaring lock.
- WIN_LEN, 256: length of the loss-of-lock observation window, in valid bits.
- LOSS_THRESH, 8: number of errors within one window that forces a return to HUNT.
- ERR_W, 16: width of the error counter.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; asynchronous, active-high.
- bit_in, input, 1: received PRBS bit.
- bit_valid, input, 1: qualifies bit_in. One bit is consumed per cycle when high.
- clr_cnt, input, 1: synchronous clear of err_count and lock_lost.
- locked, output, 1: high while in LOCKED.
- err_pulse, output, 1: one-cycle pulse per detected bit error.
- err_count, output, ERR_W: saturating error count since reset or the last clr_cnt.
- lock_lost, output, 1: sticky; set on any LOCKED->HUNT transition.

Behaviour:
- Reset:
  - Asynchronous while rst_n=1.
  - sr (31-bit history) = 0; state = HUNT; fill, match, window and window-error counters = 0.
  - locked = 0, err_pulse = 0, err_count = 0, lock_lost = 0.
  - Reset asserted mid-operation discards all state immediately.
- Prediction and outputs:
  - sr[0] holds the newest bit.
  - Expected bit exp = sr[27] ^ sr[30], evaluated on sr before the shift.
  - All outputs are registered. An effect caused by the valid bit sampled at edge N is visible after edge N.
  - bit_valid=0: no state change; err_pulse = 0.
- HUNT state (per valid bit):
  - Shift bit_in into sr, i.e. self-sync on received data.
  - While fill < 31: increment fill; no comparison is made.
  - When fill = 31:
    - If bit_in == exp and sr != 0: match += 1.
    - Otherwise: match = 0.
    - The sr != 0 rule means a stuck-at-0 input never locks.
  - When match reaches LOCK_COUNT: go to LOCKED, locked = 1, clear window counters.
  - err_pulse is never asserted in HUNT.
- LOCKED state (per valid bit):
  - Shift exp (not bit_in) into sr (flywheel), so a single line error gives exactly one error.
  - If bit_in != exp:
    - err_pulse = 1.
    - err_count += 1, saturating at 2^ERR_W - 1.
    - window-error count += 1.
  - Window counter counts valid bits 0..WIN_LEN-1. On wrap, the window-error count resets to 0. An error on the wrap bit counts in the new window.
  - If the window-error count reaches LOSS_THRESH:
    - Go to HUNT; locked = 0; lock_lost = 1.
    - fill, match and window counters are cleared; sr is retained but refilled: fill restarts at 0.
- clr_cnt:
  - Clears err_count and lock_lost on the next edge.
  - If an error occurs in the same cycle, err_count = 1.
  - If a lock loss occurs in the same cycle, lock_lost = 1.
  - clr_cnt does not affect state or window counters.

Test Plan:
- Ideal stream: generator seeded 1, valid every cycle -> first 31 bits fill only; locked rises after valid bit #95; err_count = 0 over 10,000 bits; err_pulse never high.
- Single flip: after lock, invert one bit -> exactly one err_pulse, one cycle after that bit; err_count = 1; locked stays 1.
- Inverted stream: after lock, invert every bit -> err_pulse on 8 consecutive bits; locked falls after the 8th; err_count = 8; lock_lost = 1. The stream continues inverted -> never relocks.
- Stuck-at-0 and stuck-at-1 inputs for 1,000 bits from reset -> locked stays 0.
- Gapped valid (bit_valid toggling 1,0) with an ideal stream -> lock after 95 valid bits (190 cycles); no errors.
- Edge cases:
  - clr_cnt coincident with an error -> err_count = 1.
  - Force err_count to saturate with ERR_W = 4 and a 7-errors-per-window pattern -> holds at 15 while locked stays 1.
  - rst_n pulsed mid-lock -> all outputs 0 immediately; relock after 95 bits.
